// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per cycle, NCHUNK cycles from accept to out_valid; result held until out_ready.
// Optional subtract port and mode enabled by defining SEQ_ADDER_SUB_EN.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [CHUNK:0]   w_csum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_accept;
  logic             w_last;

`ifdef SEQ_ADDER_SUB_EN
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub ? 1'b1 : cin;
`else
  assign w_b_eff = b;
  assign w_c0    = cin;
`endif

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == LAST);

  // Operands shift right one chunk per cycle; finished chunks enter the accumulator from the top.
  assign w_csum    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_acc_nxt = (r_acc >> CHUNK) | (WIDTH'(w_csum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = CALC;
      CALC:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_eff;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= w_c0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
    end else if (r_state == CALC) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_acc   <= w_acc_nxt;
      r_idx   <= r_idx + IDXW'(1);
      r_carry <= w_csum[CHUNK];
      // Visible result only updates once the whole word is done.
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_csum[CHUNK];
        r_ovf  <= (r_a_msb == r_b_msb) && (w_acc_nxt[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
